uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous 8N1 serial line into bytes. It uses the 16x oversampling tick from `baudx16_generator` (`o_sample_tick`). It sits between the external RX pin and the byte-consumer logic (command parser / FIFO). For each frame it emits one single-cycle valid or framing-error pulse with the received byte.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The tick constants describe one bit period of 16x oversampling.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int LAST_TICK  = OVERSAMPLE - 1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// RST_VAL sets the value both flops take on reset.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= {WIDTH{RST_VAL}};
      sync_q <= {WIDTH{RST_VAL}};
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver driven by a 16x oversampling tick.
// Emits one single-cycle valid or framing-error pulse per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam logic [3:0] MID_CNT  = 4'(MID_TICK);
  localparam logic [3:0] LAST_CNT = 4'(LAST_TICK);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state_q;
  logic [3:0]           tick_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic                 rx_prev_q;
  logic                 rx_s;
  logic                 rx_fall;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_rx_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) rx_prev_q <= 1'b1;
    else       rx_prev_q <= rx_s;
  end

  // Only a fresh high-to-low transition arms the receiver; a held-low line does not.
  assign rx_fall = rx_prev_q & ~rx_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A tick coinciding with the edge is deliberately not counted.
          if (rx_fall) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (i_sample_tick) begin
            if (tick_cnt_q == MID_CNT) begin
              if (!rx_s) begin
                state_q    <= DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (i_sample_tick) begin
            if (tick_cnt_q == LAST_CNT) begin
              shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              if (bit_cnt_q == LAST_BIT) state_q <= STOP;
              else                       bit_cnt_q <= bit_cnt_q + 3'd1;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          // Leaves mid stop bit so a back-to-back start edge is not missed.
          if (i_sample_tick) begin
            if (tick_cnt_q == LAST_CNT) begin
              data_q     <= shift_q;
              valid_q    <= rx_s;
              ferr_q     <= ~rx_s;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              tick_cnt_q <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame-level bench for uart_rx.
// Ticks every 5 clocks (16 ticks per 80-clock bit); frames observed as pulse events.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, busy;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sample_tick (tick),
    .i_rx          (rx),
    .o_data        (data),
    .o_valid       (valid),
    .o_frame_err   (ferr),
    .o_busy        (busy)
  );

  // Stand-in for the baud generator at divisor 4: one tick every 5 clocks.
  int div = 0;
  always @(negedge clk) begin
    tick = (div == 4);
    div  = (div == 4) ? 0 : div + 1;
  end

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  typedef struct {
    logic       err;
    logic [7:0] d;
    longint     cyc;
  } ev_t;
  ev_t evq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collects every output pulse as a frame event and checks pulse shape.
  logic pv = 1'b0, pe = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (valid | ferr) begin
        evq.push_back('{ferr, data, cyc});
        check("pulse_excl", {31'd0, valid & ferr}, 32'd0);
        check("busy_at_pulse", {31'd0, busy}, 32'd0);
      end
      if (pv | pe) check("pulse_width", {31'd0, valid | ferr}, 32'd0);
    end
    pv = valid;
    pe = ferr;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(80);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(80);
    end
    rx = stop;
    idle(80);
    rx = 1'b1;
  endtask

  // Reference: each frame yields exactly one event carrying its byte; kind set by stop bit.
  task automatic expect_one(input string tag, input logic [7:0] d, input logic err);
    ev_t e;
    check({tag, "_count"}, evq.size(), 32'd1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({tag, "_data"}, {24'd0, e.d}, {24'd0, d});
      check({tag, "_err"}, {31'd0, e.err}, {31'd0, err});
    end
    evq.delete();
  endtask

  initial begin
    logic [7:0] saved, b;
    logic       stop;
    ev_t        e0, e1;
    longint     gap;
    int         wait_n;

    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    idle(20);

    send_frame(8'hA5, 1'b1);
    expect_one("good_a5", 8'hA5, 1'b0);
    idle(20);

    saved = data;
    rx = 1'b0;
    idle(10);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    idle(5);
    rx = 1'b1;
    idle(50);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_no_event", evq.size(), 32'd0);
    check("glitch_data", {24'd0, data}, {24'd0, saved});
    idle(20);

    send_frame(8'h3C, 1'b0);
    idle(40);
    expect_one("ferr_3c", 8'h3C, 1'b1);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(10);
    check("b2b_count", evq.size(), 32'd2);
    if (evq.size() == 2) begin
      e0 = evq.pop_front();
      e1 = evq.pop_front();
      check("b2b_d0", {24'd0, e0.d}, 32'h00);
      check("b2b_d1", {24'd0, e1.d}, 32'hFF);
      check("b2b_kind", {30'd0, e0.err, e1.err}, 32'd0);
      gap = e1.cyc - e0.cyc;
      check("b2b_gap", {31'd0, (gap >= 790 && gap <= 810)}, 32'd1);
    end
    evq.delete();
    idle(20);

    rx = 1'b0;
    idle(2400);
    expect_one("break", 8'h00, 1'b1);
    check("break_idle", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    idle(100);
    send_frame(8'h5A, 1'b1);
    expect_one("after_break", 8'h5A, 1'b0);
    idle(20);

    b = 8'hF0;
    rx = 1'b0;
    idle(80);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle(80);
    end
    rx = b[4];
    idle(40);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_ferr", {31'd0, ferr}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    idle(38 + 320);
    check("midrst_no_event", evq.size(), 32'd0);
    idle(20);
    send_frame(8'h81, 1'b1);
    expect_one("after_rst", 8'h81, 1'b0);
    idle(20);

    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      send_frame(b, stop);
      // A low stop bit needs a high gap before the next start edge can be seen.
      wait_n = stop ? int'($urandom_range(30)) : int'($urandom_range(40, 10));
      idle(wait_n);
      expect_one("rand", b, ~stop);
    end

    idle(50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
